// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - 8-bit execute/writeback stage with forwarding and shift-add multiplier
module alu_exec_stage #(
  parameter int DW         = 8,
  parameter int AW         = 4,
  parameter int MUL_CYCLES = DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_valid,
  output logic          issue_ready,
  input  logic [3:0]    op,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  input  logic [AW-1:0] rd,
  input  logic [DW-1:0] imm,
  input  logic          use_imm,
  input  logic [DW-1:0] read_a,
  input  logic [DW-1:0] read_b,
  output logic [AW-1:0] wa,
  output logic [DW-1:0] wd,
  output logic          we,
  output logic [3:0]    flags
);

  localparam int SW = $clog2(DW);
  localparam int CW = $clog2(MUL_CYCLES + 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_wa;
  logic [DW-1:0]   r_wd;
  logic            r_we;
  logic [3:0]      r_flags;
  logic [2*DW-1:0] r_mcand;
  logic [DW-1:0]   r_mplier;
  logic [2*DW-1:0] r_acc;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_mrd;

  logic            w_accept;
  logic [DW-1:0]   w_op_a;
  logic [DW-1:0]   w_opb_reg;
  logic [DW-1:0]   w_op_b;
  logic [DW:0]     w_sum;
  logic [DW:0]     w_diff;
  logic [SW-1:0]   w_shamt;
  logic [DW:0]     w_shl;
  logic [DW:0]     w_shr;
  logic [DW-1:0]   w_res;
  logic            w_c;
  logic            w_v;
  logic [2*DW-1:0] w_acc_next;
  logic            w_mul_last;

  assign issue_ready = (r_state == S_IDLE);
  assign w_accept    = issue_valid && issue_ready;

  assign wa    = r_wa;
  assign wd    = r_wd;
  assign we    = r_we;
  assign flags = r_flags;

  // The register file only sees our write at the next edge, so bypass the pending writeback
  assign w_op_a    = (r_we && (r_wa == ra)) ? r_wd : read_a;
  assign w_opb_reg = (r_we && (r_wa == rb)) ? r_wd : read_b;
  assign w_op_b    = use_imm ? imm : w_opb_reg;

  // One extra bit on each side of the shifters catches the last bit shifted out
  assign w_sum   = {1'b0, w_op_a} + {1'b0, w_op_b};
  assign w_diff  = {1'b0, w_op_a} - {1'b0, w_op_b};
  assign w_shamt = w_op_b[SW-1:0];
  assign w_shl   = {1'b0, w_op_a} << w_shamt;
  assign w_shr   = {w_op_a, 1'b0} >> w_shamt;

  // Single-cycle ALU result and carry/overflow selection
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (op)
      4'd0: begin
        w_res = w_sum[DW-1:0];
        w_c   = w_sum[DW];
        w_v   = (w_op_a[DW-1] == w_op_b[DW-1]) && (w_sum[DW-1] != w_op_a[DW-1]);
      end
      4'd1, 4'd9: begin
        w_res = w_diff[DW-1:0];
        w_c   = w_diff[DW];
        w_v   = (w_op_a[DW-1] != w_op_b[DW-1]) && (w_diff[DW-1] != w_op_a[DW-1]);
      end
      4'd2: w_res = w_op_a & w_op_b;
      4'd3: w_res = w_op_a | w_op_b;
      4'd4: w_res = w_op_a ^ w_op_b;
      4'd5: begin
        w_res = w_shl[DW-1:0];
        w_c   = w_shl[DW];
      end
      4'd6: begin
        w_res = w_shr[DW:1];
        w_c   = w_shr[0];
      end
      4'd7: w_res = w_op_b;
      default: begin
        w_res = '0;
      end
    endcase
  end

  // Multiplier iteration: add the shifted multiplicand when the current multiplier bit is set
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mul_last = (r_cnt == CW'(MUL_CYCLES - 1));

  // Issue/multiply state machine and registered writeback port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_wa     <= '0;
      r_wd     <= '0;
      r_we     <= 1'b0;
      r_flags  <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_mrd    <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (op <= 4'd7) begin
              r_wa    <= rd;
              r_wd    <= w_res;
              r_we    <= 1'b1;
              r_flags <= {(w_res == '0), w_res[DW-1], w_c, w_v};
            end else if (op == 4'd9) begin
              r_flags <= {(w_res == '0), w_res[DW-1], w_c, w_v};
            end else if (op == 4'd8) begin
              r_mcand  <= {{DW{1'b0}}, w_op_a};
              r_mplier <= w_op_b;
              r_mrd    <= rd;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_state  <= S_MUL;
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (w_mul_last) begin
            r_wa    <= r_mrd;
            r_wd    <= w_acc_next[DW-1:0];
            r_we    <= 1'b1;
            r_flags <= {(w_acc_next[DW-1:0] == '0), w_acc_next[DW-1],
                        (w_acc_next[2*DW-1:DW] != '0), 1'b0};
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - directed bench with architectural model for alu_exec_stage
module tb_alu_exec_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       issue_valid = 1'b0;
  logic       issue_ready;
  logic [3:0] op = '0;
  logic [3:0] ra = '0;
  logic [3:0] rb = '0;
  logic [3:0] rd = '0;
  logic [7:0] imm = '0;
  logic       use_imm = 1'b0;
  logic [7:0] read_a;
  logic [7:0] read_b;
  logic [3:0] wa;
  logic [7:0] wd;
  logic       we;
  logic [3:0] flags;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  alu_exec_stage dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .op(op), .ra(ra), .rb(rb), .rd(rd), .imm(imm), .use_imm(use_imm),
    .read_a(read_a), .read_b(read_b), .wa(wa), .wd(wd), .we(we), .flags(flags)
  );

  // Physical register file fed by the DUT write port (lags by one edge)
  logic [7:0] phys_rf [16] = '{8'h00, 8'h7F, 8'h22, 8'h33, 8'h44, 8'h55, 8'h10, 8'h11,
                               8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'h03, 8'hEE, 8'hFF};
  assign read_a = phys_rf[ra];
  assign read_b = phys_rf[rb];
  always @(posedge clk) if (we) phys_rf[wa] <= wd;

  // Architectural model: register values as soon as each instruction retires
  logic [7:0] arch_rf [16] = '{8'h00, 8'h7F, 8'h22, 8'h33, 8'h44, 8'h55, 8'h10, 8'h11,
                               8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'h03, 8'hEE, 8'hFF};

  // Returns {writes, flags_update, Z, N, C, V, result[7:0]}
  function automatic logic [13:0] alu_ref(input logic [3:0] opc, input logic [7:0] a8, input logic [7:0] b8);
    int a, b, sa, sb, r, s, c, v;
    logic wr, fu;
    a = a8; b = b8;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    s = b % 8;
    wr = 1'b1; fu = 1'b1; c = 0; v = 0; r = 0;
    case (opc)
      4'd0: begin r = a + b; c = (r > 255); v = ((sa + sb) > 127) || ((sa + sb) < -128); end
      4'd1, 4'd9: begin
        r = a - b; c = (a < b); v = ((sa - sb) > 127) || ((sa - sb) < -128);
        if (opc == 4'd9) wr = 1'b0;
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: begin r = a << s; c = (s != 0) ? ((a >> (8 - s)) & 1) : 0; end
      4'd6: begin r = a >> s; c = (s != 0) ? ((a >> (s - 1)) & 1) : 0; end
      4'd7: r = b;
      4'd8: begin r = a * b; c = (r > 255); end
      default: begin wr = 1'b0; fu = 1'b0; end
    endcase
    r = r & 255;
    return {wr, fu, (r == 0), (r > 127), (c != 0), (v != 0), r[7:0]};
  endfunction

  logic [13:0] m_out;
  assign m_out = alu_ref(op, arch_rf[ra], use_imm ? imm : arch_rf[rb]);

  logic       exp_we = 1'b0;
  logic [3:0] exp_wa = '0;
  logic [7:0] exp_wd = '0;
  logic [3:0] exp_flags = '0;
  logic       exp_ready = 1'b1;
  int         mul_busy = 0;
  logic [3:0] mul_rd = '0;
  logic [7:0] mul_res = '0;
  logic [3:0] mul_fl = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_we <= 1'b0; exp_wa <= '0; exp_wd <= '0; exp_flags <= '0;
      exp_ready <= 1'b1; mul_busy <= 0;
    end else begin
      exp_we <= 1'b0;
      if (mul_busy > 0) begin
        mul_busy <= mul_busy - 1;
        if (mul_busy == 1) begin
          exp_we <= 1'b1; exp_wa <= mul_rd; exp_wd <= mul_res; exp_flags <= mul_fl;
          arch_rf[mul_rd] <= mul_res;
          exp_ready <= 1'b1;
        end
      end else if (issue_valid) begin
        if (op == 4'd8) begin
          mul_busy <= 8; mul_rd <= rd; mul_res <= m_out[7:0]; mul_fl <= m_out[11:8];
          exp_ready <= 1'b0;
        end else begin
          if (m_out[13]) begin
            exp_we <= 1'b1; exp_wa <= rd; exp_wd <= m_out[7:0];
            arch_rf[rd] <= m_out[7:0];
          end
          if (m_out[12]) exp_flags <= m_out[11:8];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_ready", 16'(issue_ready), 16'(exp_ready));
      chk("cyc_we", 16'(we), 16'(exp_we));
      chk("cyc_wa", 16'(wa), 16'(exp_wa));
      chk("cyc_wd", 16'(wd), 16'(exp_wd));
      chk("cyc_flags", 16'(flags), 16'(exp_flags));
    end
  end

  // Present one instruction and hold it until accepted; returns just after the accepting edge
  task automatic issue(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] d, input logic [7:0] im, input logic ui);
    int waitc = 0;
    op = o; ra = a; rb = b; rd = d; imm = im; use_imm = ui; issue_valid = 1'b1;
    while (!issue_ready && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    chk("issue_ready_wait", 16'(issue_ready), 16'd1);
    @(posedge clk); #1;
    issue_valid = 1'b0;
  endtask

  task automatic step(input logic [3:0] o, input logic [3:0] a, input logic [7:0] im,
                      input logic [7:0] e_wd, input logic [3:0] e_fl);
    issue(o, a, 4'd0, 4'd9, im, 1'b1);
    chk("vec_wd", 16'(wd), 16'(e_wd));
    chk("vec_flags", 16'(flags), 16'(e_fl));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_wa", 16'(wa), 16'h0);
    chk("rst_wd", 16'(wd), 16'h0);
    chk("rst_we", 16'(we), 16'h0);
    chk("rst_flags", 16'(flags), 16'h0);
    chk("rst_ready", 16'(issue_ready), 16'h1);
    @(posedge clk); #1;

    issue(4'd0, 4'd1, 4'd0, 4'd2, 8'h01, 1'b1);
    chk("add_we", 16'(we), 16'h1);
    chk("add_wa", 16'(wa), 16'h2);
    chk("add_wd", 16'(wd), 16'h80);
    chk("add_flags", 16'(flags), 16'b0101);
    chk("model_add_wd", 16'(exp_wd), 16'h80);
    chk("model_add_flags", 16'(exp_flags), 16'b0101);

    issue(4'd7, 4'd0, 4'd0, 4'd3, 8'h05, 1'b1);
    issue(4'd1, 4'd3, 4'd3, 4'd4, 8'h00, 1'b0);
    chk("sub_wa", 16'(wa), 16'h4);
    chk("sub_wd", 16'(wd), 16'h00);
    chk("sub_flags", 16'(flags), 16'b1000);

    issue(4'd7, 4'd0, 4'd0, 4'd10, 8'h20, 1'b1);
    issue(4'd0, 4'd10, 4'd0, 4'd11, 8'h01, 1'b1);
    chk("fwd_wd", 16'(wd), 16'h21);

    issue(4'd8, 4'd6, 4'd7, 4'd5, 8'h00, 1'b0);
    chk("mul_e0_we", 16'(we), 16'h0);
    chk("mul_e0_ready", 16'(issue_ready), 16'h0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k < 8) begin
        chk("mul_busy_we", 16'(we), 16'h0);
        chk("mul_busy_ready", 16'(issue_ready), 16'h0);
      end else begin
        chk("mul_we", 16'(we), 16'h1);
        chk("mul_wa", 16'(wa), 16'h5);
        chk("mul_wd", 16'(wd), 16'h10);
        chk("mul_flags", 16'(flags), 16'b0010);
        chk("mul_ready_after", 16'(issue_ready), 16'h1);
        chk("model_mul_wd", 16'(exp_wd), 16'h10);
      end
    end
    issue(4'd0, 4'd5, 4'd0, 4'd8, 8'h00, 1'b1);
    chk("mul_fwd_wd", 16'(wd), 16'h10);
    chk("mul_fwd_flags", 16'(flags), 16'b0000);

    step(4'd2, 4'd1,  8'h0F, 8'h0F, 4'b0000);
    step(4'd3, 4'd13, 8'h80, 8'h83, 4'b0100);
    step(4'd4, 4'd1,  8'h7F, 8'h00, 4'b1000);
    step(4'd5, 4'd1,  8'h03, 8'hF8, 4'b0110);
    step(4'd6, 4'd13, 8'h01, 8'h01, 4'b0010);
    step(4'd5, 4'd1,  8'h00, 8'h7F, 4'b0000);
    step(4'd1, 4'd2,  8'h01, 8'h7F, 4'b0001);
    step(4'd0, 4'd2,  8'h80, 8'h00, 4'b1011);
    step(4'd6, 4'd2,  8'h0F, 8'h01, 4'b0000);
    step(4'd7, 4'd0,  8'h11, 8'h11, 4'b0000);
    step(4'd7, 4'd0,  8'h22, 8'h22, 4'b0000);
    issue(4'd0, 4'd9, 4'd0, 4'd15, 8'h00, 1'b1);
    chk("newest_wins_wd", 16'(wd), 16'h22);

    issue(4'd9, 4'd13, 4'd0, 4'd0, 8'h05, 1'b1);
    chk("cmp_we", 16'(we), 16'h0);
    chk("cmp_flags", 16'(flags), 16'b0110);
    chk("model_cmp_flags", 16'(exp_flags), 16'b0110);
    issue(4'd10, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0);
    chk("nop_we", 16'(we), 16'h0);
    chk("nop_flags", 16'(flags), 16'b0110);

    issue(4'd8, 4'd6, 4'd7, 4'd14, 8'h00, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_wa", 16'(wa), 16'h0);
    chk("abort_wd", 16'(wd), 16'h0);
    chk("abort_we", 16'(we), 16'h0);
    chk("abort_flags", 16'(flags), 16'h0);
    chk("abort_ready", 16'(issue_ready), 16'h1);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      chk("abort_no_we", 16'(we), 16'h0);
    end
    chk("abort_idle_ready", 16'(issue_ready), 16'h1);
    chk("abort_idle_wd", 16'(wd), 16'h0);

    issue(4'd0, 4'd1, 4'd0, 4'd2, 8'h01, 1'b1);
    chk("post_reset_wd", 16'(wd), 16'h80);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute/writeback stage directly downstream of the 16x8 two-read/one-write register file.
- Consumes the file's asynchronous read data, performs one 8-bit ALU operation per accepted instruction and drives the file's write port (wa/wd/we) from registered outputs.
- Forwards its own pending writeback to cover the one-cycle write-to-read hazard.
- Contains a multi-cycle shift-add multiplier that stalls issue while it runs.

Parameters:
- DW, 8, datapath width; must match register file data width.
- AW, 4, register address width; must match register file address width.
- MUL_CYCLES, 8, multiplier iterations; equals DW.

Ports:
- clk  in  1  rising-edge clock shared with the register file
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  instruction presented this cycle
- issue_ready  out  1  stage can accept; combinational, high when state is IDLE
- op  in  4  opcode
- ra  in  AW  source A index; also drives the register file ra
- rb  in  AW  source B index; also drives the register file rb
- rd  in  AW  destination index
- imm  in  DW  immediate operand
- use_imm  in  1  operand B = imm instead of register B
- read_a  in  DW  register file read_a
- read_b  in  DW  register file read_b
- wa  out  AW  registered write address to the register file
- wd  out  DW  registered write data
- we  out  1  registered write enable; one-cycle pulse per writing instruction
- flags  out  4  registered {Z,N,C,V}

Behaviour:
- Reset (async, rst_n=0): wa=0, wd=0, we=0, flags=0, state=IDLE, multiplier accumulator/counter=0; issue_ready=1 once released. Reset mid-multiply aborts it with no write.
- Accept = issue_valid && issue_ready, sampled at the rising edge.
- Forwarding: opA = (we && wa==ra) ? wd : read_a. opB_reg uses the same rule with rb. opB = use_imm ? imm : opB_reg. Forwarding applies even when the register file would also see the write.
- Opcodes:
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR.
  - 5 SHL by opB[2:0]; 6 SHR logical by opB[2:0].
  - 7 MOV (result=opB).
  - 8 MUL (low byte of the 16-bit unsigned product).
  - 9 CMP (SUB, flags only).
  - 10-15 NOP.
- Single-cycle ops (0-7): at the accepting edge, wd=result, wa=rd, we=1 and flags update. Latency 1 cycle. Back-to-back issue every cycle.
- CMP: flags update at the accepting edge, we=0.
- NOP: we=0, flags unchanged.
- With no accept (or accept of CMP/NOP), we=0 at that edge; wa/wd hold.
- Flags:
  - Z = result==0; N = result[7].
  - ADD: C = carry out; V = signed overflow.
  - SUB/CMP: C = borrow (A<B unsigned); V = signed overflow.
  - SHL/SHR: C = last bit shifted out (0 if shift amount 0); V=0.
  - AND/OR/XOR/MOV: C=0, V=0.
  - MUL: C = product[15:8]!=0; V=0.
  - Arithmetic is modulo 2^DW.
- MUL state machine, IDLE -> MUL -> IDLE:
  - Accept edge E0: latch forwarded opA, opB and rd; clear accumulator and counter; enter MUL. At E0, we=0.
  - Edges E1..E8 perform one shift-add iteration each. issue_ready=0 throughout MUL.
  - At E8: wd=product[7:0], wa=rd, we=1, flags update, return to IDLE. issue_ready=1 in the cycle after E8.
  - Latency is 8 cycles from accept to we.
  - An instruction accepted in the cycle after E8 forwards the MUL result.
- issue_valid while issue_ready=0 is ignored. The upstream stage holds the instruction until accepted.
- Consecutive writes to the same rd: the newest registered value always wins forwarding.

Test Plan:
- Reset release -> wa=0, wd=0, we=0, flags=0000, issue_ready=1.
- r1 holds 0x7F; ADD rd=r2, ra=r1, imm=0x01, use_imm -> next cycle we=1, wa=2, wd=0x80, flags Z=0 N=1 C=0 V=1.
- MOV r3<=imm 0x05, then next cycle SUB r4=r3-r3 -> forwarding gives wd=0x00, Z=1 C=0 V=0. Check it uses the forwarded value, not stale register file data.
- MUL r5=r6*r7 with 0x10 and 0x11 -> issue_ready low for 8 cycles, single we pulse 8 cycles after accept, wd=0x10, C=1. Next issued ADD r8=r5+0 reads forwarded 0x10.
- CMP 0x03 vs 0x05 -> we=0, C=1, N=1, Z=0. Following NOP leaves flags unchanged and keeps we=0.
- Assert rst_n=0 at iteration 4 of MUL -> no we pulse, state IDLE, issue_ready=1 after release, outputs at reset values.
